// File: rtl/morse_player_if.sv
// Request/playback bundle between a Morse player and whatever drives it.
interface morse_player_if;
  logic        Start;
  logic        Clear;
  logic [23:0] chars;
  logic        dot_buzzer;
  logic        dash_buzzer;
  logic        busy;
  logic        done;
  logic        err;
  logic [9:0]  cur_seq;
  logic [1:0]  char_idx;

  modport master (
    output Start, Clear, chars,
    input  dot_buzzer, dash_buzzer, busy, done, err, cur_seq, char_idx
  );

  modport slave (
    input  Start, Clear, chars,
    output dot_buzzer, dash_buzzer, busy, done, err, cur_seq, char_idx
  );
endinterface

// File: rtl/morse_player.sv
// Plays up to three latched ASCII characters as timed Morse dot/dash tones.
module morse_player #(
  parameter int unsigned UNIT_CYCLES = 10,
  parameter int unsigned CNT_W       = 8
) (
  input  logic           clk,
  input  logic           Reset,
  morse_player_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_TONE, S_EGAP, S_LGAP, S_WGAP, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] T_UNIT = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_DASH = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_WORD = CNT_W'(4 * UNIT_CYCLES - 1);
  localparam logic [1:0]       SYM_DOT  = 2'b01;
  localparam logic [1:0]       SYM_DASH = 2'b10;

  state_t           state_q, state_d;
  logic [23:0]      chars_q, chars_d;
  logic [9:0]       seq_q, seq_d;
  logic [1:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             dot_q, dot_d;
  logic             dash_q, dash_d;

  logic [7:0]       cur_char, nxt_char;
  logic             has_next;
  logic             code_ok;
  logic [9:0]       code;

  // Builds a left-aligned symbol sequence; pat holds one bit per symbol, 1 = dash.
  function automatic logic [9:0] expand(input logic [2:0] len, input logic [4:0] pat);
    logic [9:0] s;
    s = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      if (i < 32'(len)) s[9-2*i -: 2] = pat[4-i] ? SYM_DASH : SYM_DOT;
    end
    return s;
  endfunction

  function automatic logic [10:0] xlate(input logic [7:0] c);
    logic [7:0] u;
    logic [7:0] lp;
    u  = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    lp = '0;
    case (u)
      "A": lp = {3'd2, 5'b01000};  "B": lp = {3'd4, 5'b10000};
      "C": lp = {3'd4, 5'b10100};  "D": lp = {3'd3, 5'b10000};
      "E": lp = {3'd1, 5'b00000};  "F": lp = {3'd4, 5'b00100};
      "G": lp = {3'd3, 5'b11000};  "H": lp = {3'd4, 5'b00000};
      "I": lp = {3'd2, 5'b00000};  "J": lp = {3'd4, 5'b01110};
      "K": lp = {3'd3, 5'b10100};  "L": lp = {3'd4, 5'b01000};
      "M": lp = {3'd2, 5'b11000};  "N": lp = {3'd2, 5'b10000};
      "O": lp = {3'd3, 5'b11100};  "P": lp = {3'd4, 5'b01100};
      "Q": lp = {3'd4, 5'b11010};  "R": lp = {3'd3, 5'b01000};
      "S": lp = {3'd3, 5'b00000};  "T": lp = {3'd1, 5'b10000};
      "U": lp = {3'd3, 5'b00100};  "V": lp = {3'd4, 5'b00010};
      "W": lp = {3'd3, 5'b01100};  "X": lp = {3'd4, 5'b10010};
      "Y": lp = {3'd4, 5'b10110};  "Z": lp = {3'd4, 5'b11000};
      "0": lp = {3'd5, 5'b11111};  "1": lp = {3'd5, 5'b01111};
      "2": lp = {3'd5, 5'b00111};  "3": lp = {3'd5, 5'b00011};
      "4": lp = {3'd5, 5'b00001};  "5": lp = {3'd5, 5'b00000};
      "6": lp = {3'd5, 5'b10000};  "7": lp = {3'd5, 5'b11000};
      "8": lp = {3'd5, 5'b11100};  "9": lp = {3'd5, 5'b11110};
      default: lp = '0;
    endcase
    return {(lp[7:5] != 3'd0), expand(lp[7:5], lp[4:0])};
  endfunction

  function automatic logic [7:0] char_at(input logic [23:0] c, input logic [1:0] i);
    case (i)
      2'd0:    return c[23:16];
      2'd1:    return c[15:8];
      default: return c[7:0];
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] tone_len(input logic [1:0] sym);
    return (sym == SYM_DASH) ? T_DASH : T_UNIT;
  endfunction

  always_comb begin
    state_d  = state_q;
    chars_d  = chars_q;
    seq_d    = seq_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    cur_char = char_at(chars_q, idx_q);
    nxt_char = char_at(chars_q, idx_q + 2'd1);
    has_next = (idx_q != 2'd2) && (nxt_char != 8'h00);
    {code_ok, code} = xlate(cur_char);

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start && !bus.Clear) begin
          chars_d = bus.chars;
          err_d   = 1'b0;
          idx_d   = 2'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        seq_d = code;
        if (cur_char == 8'h00) begin
          state_d = S_DONE;
        end else if (cur_char == 8'h20) begin
          cnt_d   = T_WORD;
          state_d = S_WGAP;
        end else if (code_ok) begin
          cnt_d   = tone_len(code[9:8]);
          state_d = S_TONE;
        end else begin
          err_d = 1'b1;
          if (has_next) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_TONE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          seq_d = {seq_q[7:0], 2'b00};
          if (seq_q[7:6] != 2'b00) begin
            cnt_d   = T_UNIT;
            state_d = S_EGAP;
          end else if (has_next) begin
            cnt_d   = T_DASH;
            state_d = S_LGAP;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_EGAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = tone_len(seq_q[9:8]);
          state_d = S_TONE;
        end
      end
      S_LGAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          idx_d   = idx_q + 2'd1;
          state_d = S_LOAD;
        end
      end
      S_WGAP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          if (has_next) begin
            idx_d   = idx_q + 2'd1;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Abort keeps the sticky error even if LOAD flagged a bad char this cycle.
    if (bus.Clear && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end

    // Buzzers are registered off the next state so they align with state_q.
    dot_d  = (state_d == S_TONE) && (seq_d[9:8] == SYM_DOT);
    dash_d = (state_d == S_TONE) && (seq_d[9:8] == SYM_DASH);
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      chars_q <= '0;
      seq_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      dot_q   <= 1'b0;
      dash_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chars_q <= chars_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      dot_q   <= dot_d;
      dash_q  <= dash_d;
    end
  end

  assign bus.dot_buzzer  = dot_q;
  assign bus.dash_buzzer = dash_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.err         = err_q;
  assign bus.cur_seq     = seq_q;
  assign bus.char_idx    = idx_q;

endmodule

// File: tb/tb_morse_player.sv
// Scoreboard bench: expected tone/silence segments are queued, a monitor measures and compares them.
module tb_morse_player;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  morse_player_if bus();

  morse_player #(.UNIT_CYCLES(10), .CNT_W(8)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    int kind;
    int len;
    int a;
    int b;
    int c;
  } ev_t;

  localparam int K_SIL  = 0;
  localparam int K_DOT  = 1;
  localparam int K_DASH = 2;
  localparam int K_END  = 4;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  n_events = 0;
  bit  mon_en   = 1'b1;
  bit  in_msg   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic push(input int kind, input int len, input int a, input int b, input int c);
    ev_t e;
    e = '{kind, len, a, b, c};
    sb_q.push_back(e);
  endtask

  task automatic exp_sil(input int len);
    push(K_SIL, len, 0, 0, 0);
  endtask

  task automatic exp_tone(input int kind, input int len, input int seq, input int idx);
    push(kind, len, seq, idx, 0);
  endtask

  task automatic exp_end(input int busy_n, input int done_n, input int last_done, input int err);
    push(K_END, busy_n, done_n, last_done, err);
  endtask

  task automatic exp_s(input int idx);
    exp_tone(K_DOT, 10, 10'b0101010000, idx); exp_sil(10);
    exp_tone(K_DOT, 10, 10'b0101000000, idx); exp_sil(10);
    exp_tone(K_DOT, 10, 10'b0100000000, idx);
  endtask

  task automatic exp_o(input int idx);
    exp_tone(K_DASH, 30, 10'b1010100000, idx); exp_sil(10);
    exp_tone(K_DASH, 30, 10'b1010000000, idx); exp_sil(10);
    exp_tone(K_DASH, 30, 10'b1000000000, idx);
  endtask

  task automatic check_ev(input ev_t o);
    ev_t e;
    bit  ok;
    n_checks++;
    n_events++;
    if (sb_q.size() == 0) begin
      $display("FAIL event%0d: unexpected kind=%0d len=%0d a=%0d b=%0d c=%0d",
               n_events, o.kind, o.len, o.a, o.b, o.c);
      return;
    end
    e  = sb_q.pop_front();
    ok = (o.kind == e.kind) && (o.len == e.len);
    if (e.kind != K_SIL) ok = ok && (o.a == e.a) && (o.b == e.b);
    if (e.kind == K_END) ok = ok && (o.c == e.c);
    if (ok) n_pass++;
    else $display("FAIL event%0d: got kind=%0d len=%0d a=%0d b=%0d c=%0d, expected kind=%0d len=%0d a=%0d b=%0d c=%0d",
                  n_events, o.kind, o.len, o.a, o.b, o.c, e.kind, e.len, e.a, e.b, e.c);
  endtask

  // Monitor: splits each busy window into constant-level segments.
  int  seg_kind, seg_len, seg_a, seg_b;
  int  busy_cnt, done_cnt, last_done, cur_lvl;
  ev_t obs;

  always @(negedge clk) begin
    cur_lvl = int'({bus.dash_buzzer, bus.dot_buzzer});
    if (!mon_en) begin
      in_msg = 1'b0;
    end else if (!in_msg) begin
      if (bus.busy) begin
        in_msg    = 1'b1;
        busy_cnt  = 1;
        done_cnt  = int'(bus.done);
        last_done = int'(bus.done);
        seg_kind  = cur_lvl; seg_len = 1;
        seg_a     = int'(bus.cur_seq); seg_b = int'(bus.char_idx);
      end
    end else if (bus.busy) begin
      busy_cnt++;
      done_cnt += int'(bus.done);
      last_done = int'(bus.done);
      if (cur_lvl == seg_kind) begin
        seg_len++;
      end else begin
        obs = '{seg_kind, seg_len, seg_a, seg_b, 0};
        check_ev(obs);
        seg_kind = cur_lvl; seg_len = 1;
        seg_a    = int'(bus.cur_seq); seg_b = int'(bus.char_idx);
      end
    end else begin
      obs = '{seg_kind, seg_len, seg_a, seg_b, 0};
      check_ev(obs);
      obs = '{K_END, busy_cnt, done_cnt, last_done, int'(bus.err)};
      check_ev(obs);
      in_msg = 1'b0;
    end
  end

  task automatic play(input logic [23:0] c);
    @(negedge clk);
    bus.chars = c;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((in_msg || sb_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " completes"}, int'(in_msg || sb_q.size() != 0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    int code, last, n, k;
    bit seen;

    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.Clear = 1'b0;
    bus.chars = '0;
    repeat (2) @(negedge clk);
    chk("reset busy",     int'(bus.busy), 0);
    chk("reset done",     int'(bus.done), 0);
    chk("reset dot",      int'(bus.dot_buzzer), 0);
    chk("reset dash",     int'(bus.dash_buzzer), 0);
    chk("reset err",      int'(bus.err), 0);
    chk("reset cur_seq",  int'(bus.cur_seq), 0);
    chk("reset char_idx", int'(bus.char_idx), 0);
    Reset = 1'b0;

    // SOS
    exp_sil(1); exp_s(0); exp_sil(31); exp_o(1); exp_sil(31); exp_s(2); exp_sil(1);
    exp_end(274, 1, 1, 0);
    play(24'h534F53);
    wait_idle("SOS", 600);

    // E, NUL, T : NUL ends the message
    exp_sil(1); exp_tone(K_DOT, 10, 10'b0100000000, 0); exp_sil(1);
    exp_end(12, 1, 1, 0);
    play(24'h450054);
    wait_idle("E-nul-T", 100);

    // "E T" : word space
    exp_sil(1); exp_tone(K_DOT, 10, 10'b0100000000, 0); exp_sil(72);
    exp_tone(K_DASH, 30, 10'b1000000000, 2); exp_sil(1);
    exp_end(114, 1, 1, 0);
    play(24'h452054);
    code = 1; last = -1; n = 0; seen = 1'b0;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (bus.busy) begin
        seen = 1'b1;
        if (int'(bus.char_idx) != last) begin
          code = code * 10 + int'(bus.char_idx);
          last = int'(bus.char_idx);
        end
      end else if (seen) begin
        break;
      end
    end
    chk("E-T char_idx order", code, 1012);
    wait_idle("E-T", 100);

    // A, '#', 5 : bad char skipped, err sticky
    exp_sil(1); exp_tone(K_DOT, 10, 10'b0110000000, 0); exp_sil(10);
    exp_tone(K_DASH, 30, 10'b1000000000, 0); exp_sil(32);
    exp_tone(K_DOT, 10, 10'b0101010101, 2); exp_sil(10);
    exp_tone(K_DOT, 10, 10'b0101010100, 2); exp_sil(10);
    exp_tone(K_DOT, 10, 10'b0101010000, 2); exp_sil(10);
    exp_tone(K_DOT, 10, 10'b0101000000, 2); exp_sil(10);
    exp_tone(K_DOT, 10, 10'b0100000000, 2); exp_sil(1);
    exp_end(174, 1, 1, 1);
    play(24'h412335);
    wait_idle("A#5", 400);
    repeat (3) @(negedge clk);
    chk("err sticky after A#5", int'(bus.err), 1);

    // EEE clears err on accept
    exp_sil(1);
    exp_tone(K_DOT, 10, 10'b0100000000, 0); exp_sil(31);
    exp_tone(K_DOT, 10, 10'b0100000000, 1); exp_sil(31);
    exp_tone(K_DOT, 10, 10'b0100000000, 2); exp_sil(1);
    exp_end(94, 1, 1, 0);
    play(24'h454545);
    chk("err cleared on Start", int'(bus.err), 0);
    wait_idle("EEE", 200);

    // OOO aborted 15 cycles into the first dash
    exp_sil(1); exp_tone(K_DASH, 15, 10'b1010100000, 0);
    exp_end(16, 0, 0, 0);
    play(24'h4F4F4F);
    n = 0; k = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (bus.dash_buzzer) k++;
      if (k == 15) begin
        bus.Clear = 1'b1;
        break;
      end
    end
    @(negedge clk);
    bus.Clear = 1'b0;
    wait_idle("OOO clear", 50);

    // replay from char 0
    exp_sil(1); exp_o(0); exp_sil(31); exp_o(1); exp_sil(31); exp_o(2); exp_sil(1);
    exp_end(394, 1, 1, 0);
    play(24'h4F4F4F);
    wait_idle("OOO replay", 800);

    // Start held and chars changed while busy
    exp_sil(1); exp_tone(K_DOT, 10, 10'b0100000000, 0); exp_sil(1);
    exp_end(12, 1, 1, 0);
    @(negedge clk);
    bus.chars = 24'h450000;
    bus.Start = 1'b1;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      bus.chars = 24'h540000;
      if (bus.done) begin
        bus.Start = 1'b0;
        break;
      end
    end
    bus.Start = 1'b0;
    wait_idle("Start held", 50);
    repeat (5) @(negedge clk);
    chk("no restart after held Start", int'(bus.busy), 0);

    // async reset mid-tone
    mon_en = 1'b0;
    play(24'h234500);
    n = 0; k = 0;
    while (n < 50 && k < 3) begin
      @(negedge clk);
      n++;
      if (bus.dot_buzzer) k++;
    end
    chk("pre-reset dot", int'(bus.dot_buzzer), 1);
    chk("pre-reset err", int'(bus.err), 1);
    #2 Reset = 1'b1;
    #1;
    chk("async reset dot",      int'(bus.dot_buzzer), 0);
    chk("async reset dash",     int'(bus.dash_buzzer), 0);
    chk("async reset busy",     int'(bus.busy), 0);
    chk("async reset done",     int'(bus.done), 0);
    chk("async reset err",      int'(bus.err), 0);
    chk("async reset cur_seq",  int'(bus.cur_seq), 0);
    chk("async reset char_idx", int'(bus.char_idx), 0);
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("idle after reset", int'(bus.busy), 0);
    mon_en = 1'b1;

    chk("scoreboard drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
